pc_sequencer: RTL and testbench

Controller that owns the enable/redirect inputs of prog_counter and sequences instruction fetch for the MIPS pipeline. It boots the PC after reset, stalls fetch on hazards, arbitrates redirect requests (exception, branch, jump), and drives a timed pipeline flush. It also provides a halt state that is left only by reset. It sits between the hazard unit / EX-stage branch logic and prog_counter.

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer_redirect_arbiter.sv | 30 +++
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: PC width, FSM encodings,
// default vectors and the redirect descriptor passed from the arbiter.
package pc_sequencer_pkg;

    localparam int PC_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0] DEF_EXC_VECTOR   = 32'h0000_0180;

    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_BOOT  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    typedef struct packed {
        logic                valid;
        logic [PC_WIDTH-1:0] target;
        logic                misalign;
    } redirect_t;

    function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] addr);
        return {addr[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/command bundle between hazard/branch logic (master) and the
// fetch sequencer (slave) that drives prog_counter.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic                pcs_i_stall;
    logic                pcs_i_exc_req;
    logic                pcs_i_br_req;
    logic [PC_WIDTH-1:0] pcs_i_br_target;
    logic                pcs_i_jmp_req;
    logic [PC_WIDTH-1:0] pcs_i_jmp_target;
    logic                pcs_i_halt;
    logic                pcs_o_ce;
    logic                pcs_o_change_pc;
    logic [PC_WIDTH-1:0] pcs_o_pc;
    logic                pcs_o_flush;
    logic                pcs_o_misalign;
    logic                pcs_o_halted;

    modport master (
        output pcs_i_stall, pcs_i_exc_req, pcs_i_br_req, pcs_i_br_target,
               pcs_i_jmp_req, pcs_i_jmp_target, pcs_i_halt,
        input  pcs_o_ce, pcs_o_change_pc, pcs_o_pc, pcs_o_flush,
               pcs_o_misalign, pcs_o_halted
    );

    modport slave (
        input  pcs_i_stall, pcs_i_exc_req, pcs_i_br_req, pcs_i_br_target,
               pcs_i_jmp_req, pcs_i_jmp_target, pcs_i_halt,
        output pcs_o_ce, pcs_o_change_pc, pcs_o_pc, pcs_o_flush,
               pcs_o_misalign, pcs_o_halted
    );

endinterface

// File: rtl/pc_sequencer_redirect_arbiter.sv
// Combinational priority select of redirect requests: exception > branch > jump.
// The chosen target is word-aligned; misalign flags a raw target with low bits set.
module pc_sequencer_redirect_arbiter
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic                exc_req,
    input  logic                br_req,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                jmp_req,
    input  logic [PC_WIDTH-1:0] jmp_target,
    output redirect_t           redirect
);

    logic [PC_WIDTH-1:0] raw_target;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        raw_target = '0;
        if (exc_req)      raw_target = EXC_VECTOR;
        else if (br_req)  raw_target = br_target;
        else if (jmp_req) raw_target = jmp_target;

        redirect.valid    = exc_req | br_req | jmp_req;
        redirect.target   = align_word(raw_target);
        redirect.misalign = redirect.valid && (raw_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: boots the PC, stalls on hazards, applies arbitrated redirects
// with a timed pipeline flush, and parks in HALT until reset.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = DEF_EXC_VECTOR,
    parameter int                  FLUSH_CYCLES = 2
) (
    input  logic           pcs_clk,
    input  logic           pcs_rst,
    pc_sequencer_if.slave  bus
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [2:0]          state;
    logic [CNT_W-1:0]    flush_cnt;
    logic                ce, change_pc, flush, misalign, halted;
    logic [PC_WIDTH-1:0] pc;
    logic                in_run, in_flush;
    redirect_t           redir;

    assign in_run   = (state == S_RUN);
    assign in_flush = (state == S_FLUSH);

    // During a flush only an exception may redirect; the other requests come from squashed work.
    pc_sequencer_redirect_arbiter #(.EXC_VECTOR(EXC_VECTOR)) u_arbiter (
        .exc_req    (bus.pcs_i_exc_req & (in_run | in_flush)),
        .br_req     (bus.pcs_i_br_req & in_run),
        .br_target  (bus.pcs_i_br_target),
        .jmp_req    (bus.pcs_i_jmp_req & in_run),
        .jmp_target (bus.pcs_i_jmp_target),
        .redirect   (redir)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge pcs_clk) begin
        if (!pcs_rst) begin
            state     <= S_RESET;
            flush_cnt <= '0;
            ce        <= 1'b0;
            change_pc <= 1'b0;
            pc        <= RESET_VECTOR;
            flush     <= 1'b1;
            misalign  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            change_pc <= 1'b0;
            misalign  <= 1'b0;
            case (state)
                S_RESET: begin
                    state     <= S_BOOT;
                    change_pc <= 1'b1;
                    pc        <= RESET_VECTOR;
                    ce        <= 1'b1;
                    flush     <= 1'b1;
                end
                S_BOOT: begin
                    state <= S_RUN;
                    ce    <= 1'b1;
                    flush <= 1'b0;
                end
                S_RUN, S_FLUSH: begin
                    if (redir.valid) begin
                        state     <= (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;
                        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
                        change_pc <= 1'b1;
                        pc        <= redir.target;
                        misalign  <= redir.misalign;
                        ce        <= 1'b1;
                        flush     <= 1'b1;
                    end else if (in_flush) begin
                        // The redirect cycle counts as the first flush cycle.
                        ce <= 1'b1;
                        if (flush_cnt == '0) begin
                            state <= S_RUN;
                            flush <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt - CNT_W'(1);
                            flush     <= 1'b1;
                        end
                    end else if (bus.pcs_i_halt) begin
                        state  <= S_HALT;
                        ce     <= 1'b0;
                        flush  <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        ce    <= ~bus.pcs_i_stall;
                        flush <= 1'b0;
                    end
                end
                S_HALT: begin
                    ce     <= 1'b0;
                    flush  <= 1'b0;
                    halted <= 1'b1;
                end
                default: state <= S_RESET;
            endcase
        end
    end

    assign bus.pcs_o_ce        = ce;
    assign bus.pcs_o_change_pc = change_pc;
    assign bus.pcs_o_pc        = pc;
    assign bus.pcs_o_flush     = flush;
    assign bus.pcs_o_misalign  = misalign;
    assign bus.pcs_o_halted    = halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a cycle-level behavioural model queues the
// expected outputs per edge; a negedge monitor pops and compares them.
module tb_pc_sequencer;

    localparam int          FC  = 2;
    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] EXC = 32'h0000_0180;

    typedef struct packed {
        logic        ce;
        logic        change_pc;
        logic [31:0] pc;
        logic        flush;
        logic        misalign;
        logic        halted;
    } exp_t;

    typedef enum int {PH_RESET, PH_BOOT, PH_ACTIVE, PH_HALTED} phase_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if bus();

    pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EXC), .FLUSH_CYCLES(FC)) dut (
        .pcs_clk (clk),
        .pcs_rst (rst),
        .bus     (bus)
    );

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;

    // Model state: lifecycle phase, current PC, and flush cycles left counting the current cycle.
    phase_t      phase = PH_RESET;
    logic [31:0] m_pc  = RV;
    int          fl_rem = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    function automatic exp_t model_step(input logic r, input logic stall, input logic exc,
                                        input logic br, input logic [31:0] bt,
                                        input logic jmp, input logic [31:0] jt,
                                        input logic halt);
        exp_t        e;
        logic [31:0] raw;
        bit          guarded;
        e = '{ce: 1'b0, change_pc: 1'b0, pc: m_pc, flush: 1'b0, misalign: 1'b0, halted: 1'b0};
        if (!r) begin
            phase  = PH_RESET;
            m_pc   = RV;
            fl_rem = 0;
            e.pc   = RV;
            e.flush = 1'b1;
            return e;
        end
        case (phase)
            PH_RESET: begin
                phase = PH_BOOT;
                m_pc  = RV;
                e = '{ce: 1'b1, change_pc: 1'b1, pc: RV, flush: 1'b1, misalign: 1'b0, halted: 1'b0};
            end
            PH_BOOT: begin
                phase  = PH_ACTIVE;
                fl_rem = 0;
                e.ce   = 1'b1;
            end
            PH_HALTED: e.halted = 1'b1;
            default: begin
                guarded = (fl_rem > 0) && (FC > 1);
                if (exc || (!guarded && (br || jmp))) begin
                    raw    = exc ? EXC : (br ? bt : jt);
                    m_pc   = raw & 32'hFFFF_FFFC;
                    fl_rem = FC;
                    e = '{ce: 1'b1, change_pc: 1'b1, pc: m_pc, flush: 1'b1,
                          misalign: (raw % 4) != 0, halted: 1'b0};
                end else if (guarded) begin
                    fl_rem  = fl_rem - 1;
                    e.ce    = 1'b1;
                    e.flush = fl_rem > 0;
                end else begin
                    fl_rem = 0;
                    if (halt) begin
                        phase    = PH_HALTED;
                        e.halted = 1'b1;
                    end else begin
                        e.ce = !stall;
                    end
                end
            end
        endcase
        return e;
    endfunction

    task automatic cyc(input logic r, input logic stall, input logic exc,
                       input logic br, input logic [31:0] bt,
                       input logic jmp, input logic [31:0] jt, input logic halt);
        exp_t e;
        rst                  = r;
        bus.pcs_i_stall      = stall;
        bus.pcs_i_exc_req    = exc;
        bus.pcs_i_br_req     = br;
        bus.pcs_i_br_target  = bt;
        bus.pcs_i_jmp_req    = jmp;
        bus.pcs_i_jmp_target = jt;
        bus.pcs_i_halt       = halt;
        e = model_step(r, stall, exc, br, bt, jmp, jt, halt);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ce",        32'(bus.pcs_o_ce),        32'(e.ce));
            check("change_pc", 32'(bus.pcs_o_change_pc), 32'(e.change_pc));
            check("pc",        bus.pcs_o_pc,             e.pc);
            check("flush",     32'(bus.pcs_o_flush),     32'(e.flush));
            check("misalign",  32'(bus.pcs_o_misalign),  32'(e.misalign));
            check("halted",    32'(bus.pcs_o_halted),    32'(e.halted));
        end
    end

    initial begin
        logic r, st, ex, b, j, h;
        logic [31:0] bt, jt;

        // Reset for two edges, then boot and run
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(22);
        // Three-cycle stall
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(2);
        // Branch beats jump and stall together
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        idle(4);
        // Exception arriving in the first flush cycle
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(4);
        // Misaligned jump target
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8003, 1'b0);
        idle(3);
        // Halt, ignored branch, reset recovery
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(4);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 49) != 0);
            st = ($urandom_range(0, 3) == 0);
            ex = ($urandom_range(0, 15) == 0);
            b  = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 7) == 0);
            h  = ($urandom_range(0, 39) == 0);
            bt = $urandom;
            jt = $urandom;
            cyc(r, st, ex, b, bt, j, jt, h);
        end

        idle(1);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
